// File: rtl/fpu_pkg.sv
// Shared types for the FP register-file writeback path.
package fpu_pkg;
  localparam int FREG_N = 32;

  typedef logic [4:0] freg_idx_t;

  typedef struct packed {
    freg_idx_t   rd;
    logic [31:0] data;
  } wb_entry_t;
endpackage

// File: rtl/freg_wb_ctrl_if.sv
// Issue, FP-unit result and register-file write signals of the writeback controller.
interface freg_wb_ctrl_if #(
  parameter int NUNIT = 3,
  parameter int DEPTH = 8
);
  import fpu_pkg::*;
  localparam int CW = $clog2(DEPTH + 1);

  logic                   issue_valid;
  freg_idx_t              issue_rs1;
  freg_idx_t              issue_rs2;
  freg_idx_t              issue_rd;
  logic                   issue_use1;
  logic                   issue_use2;
  logic                   issue_used;
  logic                   stall;

  logic [NUNIT-1:0]       u_valid;
  logic [5*NUNIT-1:0]     u_rd;
  logic [32*NUNIT-1:0]    u_data;

  logic                   we3;
  freg_idx_t              wa3;
  logic [31:0]            wd3;
  logic [FREG_N-1:0]      busy;
  logic                   err;
  logic [CW-1:0]          count;
  logic                   full;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd,
           issue_use1, issue_use2, issue_used,
           u_valid, u_rd, u_data,
    input  stall, we3, wa3, wd3, busy, err, count, full
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd,
           issue_use1, issue_use2, issue_used,
           u_valid, u_rd, u_data,
    output stall, we3, wa3, wd3, busy, err, count, full
  );
endinterface

// File: rtl/wb_fifo.sv
// Collision FIFO: up to NUNIT enqueues (ascending index order) and one dequeue per cycle.
module wb_fifo
  import fpu_pkg::*;
#(
  parameter int NUNIT = 3,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NUNIT-1:0] enq_i,
  input  wb_entry_t        enq_data_i [NUNIT],
  input  logic             deq_i,
  output wb_entry_t        head_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             ovf_o
);
  localparam int PW = $clog2(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    fill;
  logic             do_deq;
  logic [NUNIT-1:0] wen;
  logic [PW-1:0]    widx [NUNIT];

  // The slot freed by this cycle's dequeue is available to this cycle's enqueues.
  always_comb begin
    do_deq   = deq_i && (count_q != '0);
    fill     = count_q - CW'(do_deq);
    wr_ptr_d = wr_ptr_q;
    ovf_o    = 1'b0;
    for (int i = 0; i < NUNIT; i++) begin
      wen[i]  = 1'b0;
      widx[i] = wr_ptr_d;
      if (enq_i[i]) begin
        if (fill < CW'(DEPTH)) begin
          wen[i]   = 1'b1;
          fill     = fill + CW'(1);
          wr_ptr_d = wr_ptr_d + PW'(1);
        end else begin
          ovf_o = 1'b1;
        end
      end
    end
    rd_ptr_d = rd_ptr_q + PW'(do_deq);
    count_d  = fill;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUNIT; i++) begin
      if (wen[i]) mem_q[widx[i]] <= enq_data_i[i];
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
endmodule

// File: rtl/freg_wb_ctrl.sv
// FP register-file writeback controller: busy scoreboard, write-port selection and issue stall.
module freg_wb_ctrl
  import fpu_pkg::*;
#(
  parameter int NUNIT    = 3,
  parameter int DEPTH    = 8,
  parameter int STALL_TH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  freg_wb_ctrl_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [FREG_N-1:0] busy_q, busy_d;
  logic              err_q, err_d;

  wb_entry_t         unit_e [NUNIT];
  wb_entry_t         head;
  logic [NUNIT-1:0]  enq;
  logic              deq;
  logic              found;
  logic [CW-1:0]     count;
  logic              empty;
  logic              full;
  logic              ovf;
  logic              spurious;
  logic              accept;

  always_comb begin
    for (int i = 0; i < NUNIT; i++) begin
      unit_e[i].rd   = bus.u_rd[5*i +: 5];
      unit_e[i].data = bus.u_data[32*i +: 32];
    end
  end

  // Buffered results always go first so writes stay in arrival order.
  always_comb begin
    bus.we3 = 1'b0;
    bus.wa3 = '0;
    bus.wd3 = '0;
    deq     = 1'b0;
    found   = 1'b0;
    enq     = bus.u_valid;
    if (!empty) begin
      bus.we3 = 1'b1;
      bus.wa3 = head.rd;
      bus.wd3 = head.data;
      deq     = 1'b1;
    end else begin
      for (int i = 0; i < NUNIT; i++) begin
        if (bus.u_valid[i] && !found) begin
          found   = 1'b1;
          bus.we3 = 1'b1;
          bus.wa3 = unit_e[i].rd;
          bus.wd3 = unit_e[i].data;
          enq[i]  = 1'b0;
        end
      end
    end
  end

  wb_fifo #(
    .NUNIT (NUNIT),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .enq_i      (enq),
    .enq_data_i (unit_e),
    .deq_i      (deq),
    .head_o     (head),
    .count_o    (count),
    .empty_o    (empty),
    .full_o     (full),
    .ovf_o      (ovf)
  );

  assign bus.stall = bus.issue_valid &
                     ((bus.issue_use1 & busy_q[bus.issue_rs1]) |
                      (bus.issue_use2 & busy_q[bus.issue_rs2]) |
                      (bus.issue_used & busy_q[bus.issue_rd])  |
                      (count >= CW'(STALL_TH)));

  assign accept = bus.issue_valid & ~bus.stall & bus.issue_used;

  // A result for a register nobody is waiting on is flagged when it arrives.
  always_comb begin
    spurious = 1'b0;
    for (int i = 0; i < NUNIT; i++) begin
      if (bus.u_valid[i] && !busy_q[unit_e[i].rd]) spurious = 1'b1;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (bus.we3) busy_d[bus.wa3] = 1'b0;
    if (accept)  busy_d[bus.issue_rd] = 1'b1;
    err_d = err_q | ovf | spurious;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.err   = err_q;
  assign bus.count = count;
  assign bus.full  = full;
endmodule

// File: tb/tb_freg_wb_ctrl.sv
// Bench for freg_wb_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_freg_wb_ctrl;
  import fpu_pkg::*;
  localparam int NUNIT    = 3;
  localparam int DEPTH    = 8;
  localparam int STALL_TH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  freg_wb_ctrl_if #(.NUNIT(NUNIT), .DEPTH(DEPTH)) bus ();

  freg_wb_ctrl #(.NUNIT(NUNIT), .DEPTH(DEPTH), .STALL_TH(STALL_TH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: busy set, pending-result queue, sticky error.
  logic [31:0] m_busy;
  logic        m_err;
  wb_entry_t   m_q [$];

  logic        e_stall, e_we;
  freg_idx_t   e_wa;
  logic [31:0] e_wd;
  int          e_win;
  logic        o_stall, o_we;
  freg_idx_t   o_wa;
  logic [31:0] o_wd;

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.issue_rs1   = '0;
    bus.issue_rs2   = '0;
    bus.issue_rd    = '0;
    bus.issue_use1  = 1'b0;
    bus.issue_use2  = 1'b0;
    bus.issue_used  = 1'b0;
    bus.u_valid     = '0;
    bus.u_rd        = '0;
    bus.u_data      = '0;
  endtask

  task automatic set_issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic use1, input logic use2, input logic used);
    bus.issue_valid = 1'b1;
    bus.issue_rs1   = rs1;
    bus.issue_rs2   = rs2;
    bus.issue_rd    = rd;
    bus.issue_use1  = use1;
    bus.issue_use2  = use2;
    bus.issue_used  = used;
  endtask

  task automatic set_unit(input int i, input logic [4:0] rd, input logic [31:0] d);
    bus.u_valid[i]        = 1'b1;
    bus.u_rd[5*i +: 5]    = rd;
    bus.u_data[32*i +: 32] = d;
  endtask

  task automatic model_reset();
    m_busy = '0;
    m_err  = 1'b0;
    m_q.delete();
  endtask

  task automatic model_eval();
    e_stall = bus.issue_valid &
              ((bus.issue_use1 & m_busy[bus.issue_rs1]) |
               (bus.issue_use2 & m_busy[bus.issue_rs2]) |
               (bus.issue_used & m_busy[bus.issue_rd])  |
               (m_q.size() >= STALL_TH));
    e_win = -1;
    e_we  = 1'b0;
    e_wa  = '0;
    e_wd  = '0;
    if (m_q.size() > 0) begin
      e_we = 1'b1;
      e_wa = m_q[0].rd;
      e_wd = m_q[0].data;
    end else begin
      for (int i = 0; i < NUNIT; i++) begin
        if (bus.u_valid[i] && e_win < 0) begin
          e_win = i;
          e_we  = 1'b1;
          e_wa  = bus.u_rd[5*i +: 5];
          e_wd  = bus.u_data[32*i +: 32];
        end
      end
    end
  endtask

  task automatic model_commit();
    wb_entry_t e;
    for (int i = 0; i < NUNIT; i++)
      if (bus.u_valid[i] && !m_busy[bus.u_rd[5*i +: 5]]) m_err = 1'b1;
    if (m_q.size() > 0) void'(m_q.pop_front());
    for (int i = 0; i < NUNIT; i++) begin
      if (bus.u_valid[i] && i != e_win) begin
        e.rd   = bus.u_rd[5*i +: 5];
        e.data = bus.u_data[32*i +: 32];
        if (m_q.size() < DEPTH) m_q.push_back(e);
        else m_err = 1'b1;
      end
    end
    if (e_we) m_busy[e_wa] = 1'b0;
    if (bus.issue_valid && !e_stall && bus.issue_used) m_busy[bus.issue_rd] = 1'b1;
  endtask

  // Samples combinational outputs mid-cycle, then advances one edge.
  task automatic tick();
    @(negedge clk);
    model_eval();
    o_stall = bus.stall;
    o_we    = bus.we3;
    o_wa    = bus.wa3;
    o_wd    = bus.wd3;
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic issue_regs(input int first, input int last);
    for (int r = first; r <= last; r++) begin
      idle();
      set_issue(5'd0, 5'd0, 5'(r), 1'b0, 1'b0, 1'b1);
      tick();
    end
    idle();
  endtask

  task automatic test_reset();
    idle();
    #1 rst_n = 1'b0;
    model_reset();
    #2;
    checks++; if (bus.busy !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want 00000000", bus.busy); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
    checks++; if (bus.count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    checks++; if (bus.we3 !== 1'b0) begin errors++; $display("FAIL reset_we3: got %b want 0", bus.we3); end
    set_issue(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1);
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
    idle();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_raw_hazard();
    apply_reset();
    set_issue(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1);
    tick();
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL raw_first_stall: got %b want 0", o_stall); end
    checks++; if (bus.busy !== 32'h0000_0020) begin errors++; $display("FAIL raw_busy_set: got %h want 00000020", bus.busy); end
    idle();
    set_issue(5'd5, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1);
    tick();
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL raw_stall: got %b want 1", o_stall); end
    set_unit(0, 5'd5, 32'h3F80_0000);
    tick();
    checks++; if (o_we !== 1'b1 || o_wa !== 5'd5 || o_wd !== 32'h3F80_0000) begin
      errors++; $display("FAIL raw_write: got we=%b wa=%0d wd=%h want we=1 wa=5 wd=3f800000", o_we, o_wa, o_wd); end
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL raw_stall_during_write: got %b want 1", o_stall); end
    checks++; if (bus.busy !== 32'h0) begin errors++; $display("FAIL raw_busy_clear: got %h want 00000000", bus.busy); end
    bus.u_valid = '0;
    tick();
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL raw_accept: got stall=%b want 0", o_stall); end
    checks++; if (bus.busy !== 32'h0000_0080) begin errors++; $display("FAIL raw_busy_rd7: got %h want 00000080", bus.busy); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL raw_err: got %b want 0", bus.err); end
  endtask

  task automatic test_collision();
    logic [31:0] d [3];
    freg_idx_t   exp_wa;
    d[0] = 32'h4000_0000; d[1] = 32'h4040_0000; d[2] = 32'h4080_0000;
    apply_reset();
    issue_regs(1, 3);
    set_unit(0, 5'd1, d[0]); set_unit(1, 5'd2, d[1]); set_unit(2, 5'd3, d[2]);
    for (int k = 0; k < 3; k++) begin
      tick();
      idle();
      exp_wa = 5'(k + 1);
      checks++; if (o_we !== 1'b1 || o_wa !== exp_wa || o_wd !== d[k]) begin
        errors++; $display("FAIL collide_write%0d: got we=%b wa=%0d wd=%h want we=1 wa=%0d wd=%h", k, o_we, o_wa, o_wd, exp_wa, d[k]); end
      checks++; if (int'(bus.count) !== 2 - k) begin
        errors++; $display("FAIL collide_count%0d: got %0d want %0d", k, bus.count, 2 - k); end
    end
    checks++; if (bus.busy !== 32'h0 || bus.err !== 1'b0) begin
      errors++; $display("FAIL collide_final: got busy=%h err=%b want 00000000/0", bus.busy, bus.err); end
  endtask

  task automatic test_no_bypass();
    apply_reset();
    set_issue(5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b1); tick();
    set_issue(5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1); tick();
    set_issue(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1); tick();
    idle();
    set_unit(0, 5'd7, 32'h0000_0777); set_unit(1, 5'd4, 32'h0000_0444);
    tick();
    idle();
    set_unit(0, 5'd6, 32'h0000_0666);
    tick();
    checks++; if (o_we !== 1'b1 || o_wa !== 5'd4 || o_wd !== 32'h0000_0444) begin
      errors++; $display("FAIL nobypass_first: got we=%b wa=%0d wd=%h want we=1 wa=4 wd=00000444", o_we, o_wa, o_wd); end
    idle();
    tick();
    checks++; if (o_we !== 1'b1 || o_wa !== 5'd6 || o_wd !== 32'h0000_0666) begin
      errors++; $display("FAIL nobypass_second: got we=%b wa=%0d wd=%h want we=1 wa=6 wd=00000666", o_we, o_wa, o_wd); end
    checks++; if (bus.count !== '0 || bus.err !== 1'b0) begin
      errors++; $display("FAIL nobypass_final: got count=%0d err=%b want 0/0", bus.count, bus.err); end
  endtask

  task automatic test_stall_threshold();
    apply_reset();
    issue_regs(10, 15);
    set_unit(0, 5'd10, 32'd10); set_unit(1, 5'd11, 32'd11); set_unit(2, 5'd12, 32'd12);
    tick();
    idle();
    set_unit(0, 5'd13, 32'd13); set_unit(1, 5'd14, 32'd14); set_unit(2, 5'd15, 32'd15);
    tick();
    checks++; if (int'(bus.count) !== 4) begin errors++; $display("FAIL th_count4: got %0d want 4", bus.count); end
    idle();
    set_issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL th_stall_at4: got %b want 1", o_stall); end
    checks++; if (int'(bus.count) !== 3) begin errors++; $display("FAIL th_count3: got %0d want 3", bus.count); end
    tick();
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL th_stall_at3: got %b want 0", o_stall); end
  endtask

  task automatic test_overflow();
    apply_reset();
    issue_regs(1, 15);
    for (int c = 0; c < 5; c++) begin
      for (int u = 0; u < NUNIT; u++) set_unit(u, 5'(3*c + u + 1), 32'(100 + 3*c + u));
      tick();
      idle();
      if (c == 3) begin
        checks++; if (int'(bus.count) !== 8 || bus.err !== 1'b0) begin
          errors++; $display("FAIL ovf_full: got count=%0d err=%b want 8/0", bus.count, bus.err); end
      end
    end
    checks++; if (bus.err !== 1'b1 || bus.full !== 1'b1) begin
      errors++; $display("FAIL ovf_err: got err=%b full=%b want 1/1", bus.err, bus.full); end
    repeat (4) tick();
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", bus.err); end

    apply_reset();
    set_unit(1, 5'd9, 32'hDEAD_BEEF);
    tick();
    idle();
    checks++; if (o_we !== 1'b1 || o_wa !== 5'd9 || o_wd !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL spurious_write: got we=%b wa=%0d wd=%h want we=1 wa=9 wd=deadbeef", o_we, o_wa, o_wd); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL spurious_err: got %b want 1", bus.err); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    issue_regs(1, 6);
    set_unit(0, 5'd1, 32'd1); set_unit(1, 5'd2, 32'd2); set_unit(2, 5'd3, 32'd3);
    tick();
    idle();
    set_unit(0, 5'd4, 32'd4); set_unit(1, 5'd5, 32'd5);
    tick();
    idle();
    checks++; if (int'(bus.count) !== 3) begin errors++; $display("FAIL midrst_pre_count: got %0d want 3", bus.count); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.we3 !== 1'b0 || bus.busy !== 32'h0 || bus.count !== '0) begin
      errors++; $display("FAIL midrst_clear: got we3=%b busy=%h count=%0d want 0/00000000/0", bus.we3, bus.busy, bus.count); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_unit(0, 5'd6, 32'd6);
    tick();
    idle();
    checks++; if (o_we !== 1'b1 || o_wa !== 5'd6 || bus.err !== 1'b1) begin
      errors++; $display("FAIL midrst_inflight: got we=%b wa=%0d err=%b want 1/6/1", o_we, o_wa, bus.err); end
  endtask

  function automatic logic [4:0] pick_rd();
    int s;
    if (m_busy == '0 || $urandom_range(0, 15) == 0) return 5'($urandom_range(0, 31));
    s = $urandom_range(0, 31);
    for (int k = 0; k < 32; k++)
      if (m_busy[(s + k) % 32]) return 5'((s + k) % 32);
    return 5'(s);
  endfunction

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      idle();
      if ($urandom_range(0, 1) == 1)
        set_issue(5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      for (int u = 0; u < NUNIT; u++)
        if ($urandom_range(0, 3) == 0) set_unit(u, pick_rd(), $urandom());
      tick();
      checks++; if (o_stall !== e_stall) begin errors++; $display("FAIL rnd_stall@%0d: got %b want %b", n, o_stall, e_stall); end
      checks++; if (o_we !== e_we) begin errors++; $display("FAIL rnd_we@%0d: got %b want %b", n, o_we, e_we); end
      if (e_we) begin
        checks++; if (o_wa !== e_wa || o_wd !== e_wd) begin
          errors++; $display("FAIL rnd_wdata@%0d: got wa=%0d wd=%h want wa=%0d wd=%h", n, o_wa, o_wd, e_wa, e_wd); end
      end
      checks++; if (bus.busy !== m_busy) begin errors++; $display("FAIL rnd_busy@%0d: got %h want %h", n, bus.busy, m_busy); end
      checks++; if (bus.err !== m_err) begin errors++; $display("FAIL rnd_err@%0d: got %b want %b", n, bus.err, m_err); end
      checks++; if (int'(bus.count) !== m_q.size() || bus.full !== (m_q.size() == DEPTH)) begin
        errors++; $display("FAIL rnd_count@%0d: got count=%0d full=%b want %0d", n, bus.count, bus.full, m_q.size()); end
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_raw_hazard();
    test_collision();
    test_no_bypass();
    test_stall_threshold();
    test_overflow();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
